// File: rtl/m_cache_refill_ctrl_if.sv
// Bus bundle for the cache refill controller: CPU lookup side, memory read side
// and cache line write port.
interface m_cache_refill_ctrl_if;
  logic        w_req;
  logic [31:0] w_address;
  logic        w_hit;
  logic        w_stall;
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_mem_ack;
  logic [31:0] w_mem_rdata;
  logic        w_we;
  logic [4:0]  w_wa;
  logic [57:0] w_wd;
  logic [31:0] w_miss_count;

  modport slave (
    input  w_req, w_address, w_hit, w_mem_ack, w_mem_rdata,
    output w_stall, w_mem_req, w_mem_addr, w_we, w_wa, w_wd, w_miss_count
  );

  modport master (
    output w_req, w_address, w_hit, w_mem_ack, w_mem_rdata,
    input  w_stall, w_mem_req, w_mem_addr, w_we, w_wa, w_wd, w_miss_count
  );
endinterface

// File: rtl/m_cache_refill_ctrl.sv
// Direct-mapped cache refill controller: 32 lines x 32-bit word, 25-bit tag.
// A load miss fetches one word from memory, writes the line, then replays the access.
module m_cache_refill_ctrl (
  input  logic                         w_clock,
  input  logic                         w_reset,
  m_cache_refill_ctrl_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MREQ   = 2'd1,
    S_FILL   = 2'd2,
    S_REPLAY = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_miss_count;
  logic        r_mem_req;
  logic        r_we;
  logic        w_unused_lsb;

  // Byte offset never takes part in fill addressing.
  assign w_unused_lsb = ^r_addr[1:0];

  // Refill sequencer with registered memory request and line write strobe.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_miss_count <= 32'd0;
      r_mem_req    <= 1'b0;
      r_we         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (bus.w_req && !bus.w_hit) begin
            r_addr    <= bus.w_address;
            r_mem_req <= 1'b1;
            r_state   <= S_MREQ;
            if (r_miss_count != 32'hFFFF_FFFF) begin
              r_miss_count <= r_miss_count + 32'd1;
            end
          end else begin
            r_mem_req <= 1'b0;
          end
        end
        S_MREQ: begin
          if (bus.w_mem_ack) begin
            r_data    <= bus.w_mem_rdata;
            r_mem_req <= 1'b0;
            r_we      <= 1'b1;
            r_state   <= S_FILL;
          end else begin
            r_mem_req <= 1'b1;
          end
        end
        S_FILL: begin
          r_we    <= 1'b0;
          r_state <= S_REPLAY;
        end
        S_REPLAY: begin
          r_we      <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_we      <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Stall must react in the same cycle the miss is seen, so it is combinational.
  always_comb begin
    bus.w_stall = 1'b0;
    case (r_state)
      S_IDLE:   bus.w_stall = bus.w_req & ~bus.w_hit;
      S_MREQ:   bus.w_stall = 1'b1;
      S_FILL:   bus.w_stall = 1'b1;
      S_REPLAY: bus.w_stall = 1'b0;
      default:  bus.w_stall = 1'b0;
    endcase
  end

  assign bus.w_mem_req    = r_mem_req;
  assign bus.w_mem_addr   = {r_addr[31:2], 2'b00};
  assign bus.w_we         = r_we;
  assign bus.w_wa         = r_addr[6:2];
  // Valid bit follows the strobe so the idle value after reset is all zero.
  assign bus.w_wd         = {r_we, r_addr[31:7], r_data};
  assign bus.w_miss_count = r_miss_count;

endmodule

// File: tb/tb_m_cache_refill_ctrl.sv
// Randomized bench for m_cache_refill_ctrl, checked against a transaction-level
// model holding the cache contents and the expected refill timeline.
module tb_m_cache_refill_ctrl;

  logic w_clock = 1'b0;
  logic w_reset = 1'b1;
  m_cache_refill_ctrl_if bus ();

  m_cache_refill_ctrl dut (
    .w_clock (w_clock),
    .w_reset (w_reset),
    .bus     (bus)
  );

  always #5 w_clock = ~w_clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_valid [32];
  logic [24:0] m_tag   [32];
  logic [31:0] m_count = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[a[6:2]] && (m_tag[a[6:2]] == a[31:7]);
  endfunction

  task automatic next_cycle();
    @(posedge w_clock);
    #1;
  endtask

  task automatic apply_reset();
    w_reset = 1'b1;
    bus.w_req = 1'b1; bus.w_hit = 1'b0; bus.w_address = 32'h1234_5678;
    bus.w_mem_ack = 1'b0; bus.w_mem_rdata = 32'd0;
    next_cycle();
    next_cycle();
    @(negedge w_clock);
    check_eq("rst_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    check_eq("rst_we", {63'd0, bus.w_we}, 64'd0);
    check_eq("rst_mem_addr", {32'd0, bus.w_mem_addr}, 64'd0);
    check_eq("rst_wa", {59'd0, bus.w_wa}, 64'd0);
    check_eq("rst_wd", {6'd0, bus.w_wd}, 64'd0);
    check_eq("rst_count", {32'd0, bus.w_miss_count}, 64'd0);
    check_eq("rst_stall", {63'd0, bus.w_stall}, 64'd1);
    next_cycle();
    w_reset = 1'b0;
    bus.w_req = 1'b0;
    m_count = 32'd0;
  endtask

  // One CPU access; on a miss the model walks IDLE, delay+1 request cycles, FILL, REPLAY.
  task automatic do_access(input logic [31:0] addr, input int delay, input logic [31:0] data);
    logic hit;
    hit = model_hit(addr);
    bus.w_req = 1'b1; bus.w_address = addr; bus.w_hit = hit;
    bus.w_mem_ack = 1'($urandom_range(0, 1)); bus.w_mem_rdata = $urandom;
    @(negedge w_clock);
    check_eq("idle_stall", {63'd0, bus.w_stall}, {63'd0, ~hit});
    check_eq("idle_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    check_eq("idle_we", {63'd0, bus.w_we}, 64'd0);
    check_eq("idle_count", {32'd0, bus.w_miss_count}, {32'd0, m_count});
    next_cycle();
    if (hit) return;
    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    for (int k = 0; k <= delay; k++) begin
      bus.w_req = 1'($urandom_range(0, 1)); bus.w_address = $urandom;
      bus.w_hit = 1'($urandom_range(0, 1));
      bus.w_mem_ack = (k == delay);
      bus.w_mem_rdata = (k == delay) ? data : $urandom;
      @(negedge w_clock);
      check_eq("mreq_mem_req", {63'd0, bus.w_mem_req}, 64'd1);
      check_eq("mreq_addr", {32'd0, bus.w_mem_addr}, {32'd0, addr[31:2], 2'b00});
      check_eq("mreq_stall", {63'd0, bus.w_stall}, 64'd1);
      check_eq("mreq_we", {63'd0, bus.w_we}, 64'd0);
      next_cycle();
    end
    bus.w_mem_ack = 1'($urandom_range(0, 1)); bus.w_mem_rdata = $urandom;
    bus.w_address = $urandom;
    @(negedge w_clock);
    check_eq("fill_we", {63'd0, bus.w_we}, 64'd1);
    check_eq("fill_wa", {59'd0, bus.w_wa}, {59'd0, addr[6:2]});
    check_eq("fill_wd", {6'd0, bus.w_wd}, {6'd0, 1'b1, addr[31:7], data});
    check_eq("fill_stall", {63'd0, bus.w_stall}, 64'd1);
    check_eq("fill_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    check_eq("fill_count", {32'd0, bus.w_miss_count}, {32'd0, m_count});
    m_valid[addr[6:2]] = 1'b1;
    m_tag[addr[6:2]] = addr[31:7];
    next_cycle();
    bus.w_req = 1'b1; bus.w_address = addr; bus.w_hit = 1'($urandom_range(0, 1));
    bus.w_mem_ack = 1'($urandom_range(0, 1));
    @(negedge w_clock);
    check_eq("replay_stall", {63'd0, bus.w_stall}, 64'd0);
    check_eq("replay_we", {63'd0, bus.w_we}, 64'd0);
    check_eq("replay_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    next_cycle();
  endtask

  task automatic idle_cycle();
    bus.w_req = 1'b0; bus.w_hit = 1'($urandom_range(0, 1)); bus.w_address = $urandom;
    bus.w_mem_ack = 1'($urandom_range(0, 1)); bus.w_mem_rdata = $urandom;
    @(negedge w_clock);
    check_eq("noreq_stall", {63'd0, bus.w_stall}, 64'd0);
    check_eq("noreq_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    check_eq("noreq_we", {63'd0, bus.w_we}, 64'd0);
    next_cycle();
  endtask

  // Reset lands in the request phase together with an ack; the refill must vanish.
  task automatic reset_mid_mreq(input logic [31:0] addr);
    bus.w_req = 1'b1; bus.w_address = addr; bus.w_hit = 1'b0; bus.w_mem_ack = 1'b0;
    next_cycle();
    @(negedge w_clock);
    check_eq("abort_mreq_up", {63'd0, bus.w_mem_req}, 64'd1);
    next_cycle();
    w_reset = 1'b1; bus.w_mem_ack = 1'b1; bus.w_mem_rdata = 32'hCAFE_F00D;
    next_cycle();
    w_reset = 1'b0; bus.w_req = 1'b0; bus.w_mem_ack = 1'b1;
    m_count = 32'd0;
    @(negedge w_clock);
    check_eq("abort_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    check_eq("abort_we", {63'd0, bus.w_we}, 64'd0);
    check_eq("abort_stall", {63'd0, bus.w_stall}, 64'd0);
    check_eq("abort_count", {32'd0, bus.w_miss_count}, 64'd0);
    next_cycle();
    bus.w_mem_ack = 1'b0;
    @(negedge w_clock);
    check_eq("abort_late_we", {63'd0, bus.w_we}, 64'd0);
    check_eq("abort_late_mem_req", {63'd0, bus.w_mem_req}, 64'd0);
    next_cycle();
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i] = 25'd0;
    end
    bus.w_req = 1'b0; bus.w_address = 32'd0; bus.w_hit = 1'b0;
    bus.w_mem_ack = 1'b0; bus.w_mem_rdata = 32'd0;
    apply_reset();

    do_access(32'h0000_0084, 0, 32'hDEAD_BEEF);
    check_eq("cold_count", {32'd0, bus.w_miss_count}, 64'd1);
    do_access(32'h0000_0084, 0, 32'd0);
    check_eq("hit_count", {32'd0, bus.w_miss_count}, 64'd1);
    do_access(32'h0000_0004, 10, 32'h1111_2222);
    do_access(32'h0000_0087, 0, 32'h3333_4444);
    check_eq("conflict_count", {32'd0, bus.w_miss_count}, 64'd3);

    reset_mid_mreq(32'h0000_0F00);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      a = {23'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = $urandom;
      do_access(a, $urandom_range(0, 5), $urandom);
    end

    force dut.r_miss_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_miss_count;
    m_count = 32'hFFFF_FFFE;
    for (int n = 0; n < 3; n++) begin
      a = $urandom;
      m_valid[a[6:2]] = 1'b0;
      do_access(a, 1, $urandom);
    end
    check_eq("sat_count", {32'd0, bus.w_miss_count}, 64'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m_cache_refill_ctrl.md
M_CACHE_REFILL_CTRL -- requirements
Module: m_cache_refill_ctrl

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 32 lines x 32-bit word, 25-bit tag, 1 valid bit, and the fill word is 58 bits.
REQ-002 w_clock  input  1  single clock; all state changes on its rising edge.
REQ-003 w_reset  input  1  synchronous, active-high reset.
REQ-004 w_req  input  1  CPU load request valid this cycle.
REQ-005 w_address  input  32  CPU load byte address; the same address drives the cache lookup.
REQ-006 w_hit  input  1  cache lookup hit for w_address.
REQ-007 w_stall  output  1  CPU shall hold w_req/w_address while this is high.
REQ-008 w_mem_req  output  1  memory word-read request; held high until it is acknowledged.
REQ-009 w_mem_addr  output  32  word-aligned memory read address.
REQ-010 w_mem_ack  input  1  memory read-data-valid strobe, one cycle.
REQ-011 w_mem_rdata  input  32  memory read data; valid when w_mem_ack=1.
REQ-012 w_we  output  1  cache line write enable, one-cycle pulse.
REQ-013 w_wa  output  5  cache line index to write.
REQ-014 w_wd  output  58  cache line write data, arranged as {valid, tag[24:0], data[31:0]}.
REQ-015 w_miss_count  output  32  number of misses accepted since reset.

Function
REQ-016 SHALL implement a 4-state FSM: IDLE, MREQ, FILL, REPLAY.
REQ-017 IDLE: when w_req=1 and w_hit=0, SHALL capture w_address into r_addr, increment w_miss_count, and go to MREQ; otherwise remain in IDLE.
REQ-018 w_stall SHALL equal (w_req & ~w_hit) combinationally in IDLE, 1 in MREQ and FILL, and 0 in REPLAY.
REQ-019 MREQ: w_mem_req=1 and w_mem_addr={r_addr[31:2],2'b00}; both SHALL be stable until w_mem_ack=1 is sampled.
REQ-020 MREQ: on w_mem_ack=1, SHALL register w_mem_rdata and go to FILL; with no ack, remain in MREQ indefinitely (no timeout).
REQ-021 An ack in the first MREQ cycle is legal, giving a minimum miss penalty of 3 stall cycles (IDLE detect, MREQ, FILL).
REQ-022 FILL: w_we=1 for exactly one cycle, w_wa=r_addr[6:2], w_wd={1'b1, r_addr[31:7], registered data}; next state is REPLAY.
REQ-023 REPLAY: stall is deasserted so the CPU completes the access against the now-valid line; no miss detection occurs; next state is IDLE.
REQ-024 Outside FILL, w_we SHALL be 0; w_wa and w_wd are don't-care but SHALL be driven from r_addr and the data register (no X).
REQ-025 Outside MREQ, w_mem_req SHALL be 0; w_mem_ack outside MREQ SHALL be ignored.
REQ-026 Changes of w_req or w_address after a miss is accepted SHALL NOT affect the refill in progress; the refill always completes for r_addr.
REQ-027 w_address[1:0] SHALL be ignored for fill addressing.
REQ-028 w_miss_count SHALL saturate at 32'hFFFF_FFFF (no wrap).
REQ-029 A miss to an index holding a different valid tag SHALL overwrite it; there is no write-back.

Reset
REQ-030 When w_reset=1 at a rising edge, the state SHALL become IDLE, and r_addr, the data register and w_miss_count SHALL become 0.
REQ-031 After reset: w_mem_req=0, w_we=0, w_mem_addr=0, w_wa=0, w_wd=0, and w_stall=(w_req & ~w_hit).
REQ-032 Reset asserted in MREQ or FILL SHALL abort the refill: w_mem_req and w_we are 0 from the next cycle, no cache write occurs, and a late w_mem_ack is ignored.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Cold miss: w_req=1, w_address=32'h0000_0084, w_hit=0, ack with rdata=32'hDEAD_BEEF in the first MREQ cycle -> w_mem_addr=32'h0000_0084; a FILL pulse with w_wa=5'd1 and w_wd={1,25'h1,32'hDEADBEEF}; stall for 3 cycles, 0 in REPLAY; w_miss_count=1.
REQ-035 Hit: w_req=1, w_hit=1 in IDLE -> w_stall=0, w_mem_req never rises, w_miss_count unchanged.
REQ-036 Slow memory: ack delayed 10 cycles -> w_mem_req high and w_mem_addr stable for 10 cycles, w_stall high throughout, exactly one w_we pulse.
REQ-037 Conflict miss: fill 32'h0000_0004, then miss on 32'h0000_0084 (same index 1) -> second fill writes w_wa=1 with tag 25'h1; w_miss_count=2.
REQ-038 Reset mid-MREQ, then ack on the following cycle -> no w_we pulse; state is IDLE; w_miss_count=0.
REQ-039 Saturation: preload the counter near its maximum by driving 2^32-1 misses (or force in simulation), then one more miss -> w_miss_count stays at 32'hFFFF_FFFF.
